fp_align_shifter: RTL and testbench
===================================

FP_ALIGN_SHIFTER -- requirements
Module: fp_align_shifter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 28, mantissa width (including guard bits).
REQ-003 SHALL have parameter STAGES, default 2, pipeline register stages, legal 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port op  input  2  mode: 00 left-by-diff, 01 right-by-diff, 10 right-to-target, 11 normalize-left.
REQ-009 SHALL have port exp  input  EXP_W  operand exponent.
REQ-010 SHALL have port mantis  input  MAN_W  operand mantissa.
REQ-011 SHALL have port exp_arg  input  EXP_W  shift distance (op 00/01) or target exponent (op 10); ignored for op 11.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port exp_out  output  EXP_W  result exponent.
REQ-015 SHALL have port mantis_out  output  MAN_W  result mantissa.
REQ-016 SHALL have port loss  output  1  nonzero bits shifted out.
REQ-017 SHALL have port ovf  output  1  exponent overflow/saturation (op 01), or target below exp (op 10).
REQ-018 SHALL have port zero  output  1  mantis_out is all zeros.

Function
REQ-019 Pipeline SHALL advance when en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-020 Latency SHALL be exactly STAGES enabled cycles from acceptance to out_valid; bubbles are carried, not compressed.
REQ-021 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-022 op 00: exp_out = exp - exp_arg (mod 2^EXP_W); mantis_out = mantis << exp_arg; loss = OR of bits shifted past MSB.
REQ-023 op 01: {ovf, exp_out} = exp + exp_arg (EXP_W+1 bits); if ovf or exp_out is all-ones, mantis_out = 0 and exp_out = all-ones; otherwise mantis_out = mantis >> exp_arg.
REQ-024 op 01/10: loss SHALL be the OR of all bits shifted below LSB; if shift >= MAN_W, mantis_out = 0 and loss = |mantis.
REQ-025 op 10: exp_out = exp_arg, and shift = exp_arg - exp; if exp_arg < exp, SHALL pass mantis/exp unchanged with ovf=1, loss=0.
REQ-026 op 11: lz = leading zeros of mantis; shift = min(lz, exp); exp_out = exp - shift; mantis_out = mantis << shift; loss = 0.
REQ-027 op 11 with mantis == 0: exp_out = 0, mantis_out = 0, zero = 1.
REQ-028 Shift decomposition: each stage SHALL apply a disjoint subset of shift-amount bits so the full shift completes by stage STAGES.
REQ-029 Shift amounts SHALL be treated as unsigned EXP_W-bit values; no wrap into the opposite direction.

Reset
REQ-030 On rst, all stage valid bits and out_valid SHALL clear on the next rising edge; exp_out, mantis_out, loss, ovf, zero SHALL reset to 0.
REQ-031 rst mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 the cycle after reset deasserts.

Configuration
REQ-032 Macro FP_SHIFTER_STICKY_EN defined: loss is computed as in REQ-022..026 and carried through every stage.
REQ-033 Macro FP_SHIFTER_STICKY_EN undefined: loss SHALL be constant 0 and no sticky logic or registers are synthesized; all other outputs are unchanged.

Verification
REQ-034 STAGES=2, op 01, exp=0x10, mantis=0x8000001, exp_arg=4 -> after 2 cycles exp_out=0x14, mantis_out=0x0800000, loss=1 (sticky en).
REQ-035 op 01, exp=0xFE, exp_arg=0x05 -> ovf=1, exp_out=0xFF, mantis_out=0.
REQ-036 op 11, exp=0x03, mantis=0x0000F00 -> shift=3, exp_out=0x00, mantis_out=0x0007800; mantis=0 -> zero=1, exp_out=0.
REQ-037 op 10, exp=0x20, exp_arg=0x10 -> ovf=1, outputs equal inputs; exp_arg=0x40 -> mantis_out=0, loss=|mantis.
REQ-038 Back-to-back beats with out_ready toggling 1,0,0,1 -> no beat lost or duplicated, outputs stable during stall, in-order results.
REQ-039 Assert rst with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted afterward.

Source files
------------

// File: rtl/fp_align_shifter.sv
// Pipelined floating-point mantissa alignment shifter (left/right by distance, to target, normalize).
// Define FP_SHIFTER_STICKY_EN to build the sticky/loss tracking; otherwise loss is tied low.
module fp_align_shifter #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned MAN_W  = 28,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [EXP_W-1:0] exp,
   input  logic [MAN_W-1:0] mantis,
   input  logic [EXP_W-1:0] exp_arg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EXP_W-1:0] exp_out,
   output logic [MAN_W-1:0] mantis_out,
   output logic             loss,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned SH_W = (MAN_W > 1) ? $clog2(MAN_W) : 1;
   localparam int unsigned CW   = (EXP_W > 32) ? EXP_W : 32;

   typedef enum logic [1:0] {
      OP_LSH = 2'b00,
      OP_RSH = 2'b01,
      OP_TGT = 2'b10,
      OP_NRM = 2'b11
   } op_e;

   logic             en;
   logic             pre_left;
   logic [SH_W-1:0]  pre_amt;
   logic [MAN_W-1:0] pre_mant;
   logic [EXP_W-1:0] pre_exp;
   logic [EXP_W-1:0] raw_amt;
   logic             pre_ovf;
   logic [EXP_W:0]   rsh_sum;
   int unsigned      lz;
   int unsigned      nrm_sh;
   logic             zero_q;
`ifdef FP_SHIFTER_STICKY_EN
   logic             pre_loss;
`endif

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin : p_lz
      lz = MAN_W;
      for (int unsigned i = 0; i < MAN_W; i++) begin
         if (mantis[i]) lz = MAN_W - 1 - i;
      end
      nrm_sh = lz;
      if (CW'(exp) < CW'(lz)) nrm_sh = 32'(exp);
   end

   always_comb begin : p_pre
      rsh_sum  = {1'b0, exp} + {1'b0, exp_arg};
      pre_left = 1'b0;
      raw_amt  = '0;
      pre_exp  = exp;
      pre_mant = mantis;
      pre_ovf  = 1'b0;
      pre_amt  = '0;
`ifdef FP_SHIFTER_STICKY_EN
      pre_loss = 1'b0;
`endif
      case (op_e'(op))
         OP_LSH: begin
            pre_left = 1'b1;
            raw_amt  = exp_arg;
            pre_exp  = exp - exp_arg;
         end
         OP_RSH: begin
            pre_ovf = rsh_sum[EXP_W];
            pre_exp = rsh_sum[EXP_W-1:0];
            if (rsh_sum[EXP_W] || (&rsh_sum[EXP_W-1:0])) begin
               pre_exp  = '1;
`ifdef FP_SHIFTER_STICKY_EN
               pre_loss = |mantis;
`endif
               pre_mant = '0;
            end else begin
               raw_amt = exp_arg;
            end
         end
         OP_TGT: begin
            if (exp_arg < exp) begin
               pre_ovf = 1'b1;
            end else begin
               pre_exp = exp_arg;
               raw_amt = exp_arg - exp;
            end
         end
         default: begin
            pre_left = 1'b1;
            if (mantis == '0) begin
               pre_exp = '0;
            end else begin
               raw_amt = EXP_W'(nrm_sh);
               pre_exp = exp - raw_amt;
            end
         end
      endcase
      // Distances of a full mantissa or more are resolved here so stages only see SH_W bits.
      if (CW'(raw_amt) >= CW'(MAN_W)) begin
`ifdef FP_SHIFTER_STICKY_EN
         pre_loss = pre_loss | (|pre_mant);
`endif
         pre_mant = '0;
      end else begin
         pre_amt = SH_W'(raw_amt);
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int unsigned SIDX = s;
      logic             src_vld;
      logic             src_left;
      logic             src_ovf;
      logic [SH_W-1:0]  src_amt;
      logic [MAN_W-1:0] src_mant;
      logic [EXP_W-1:0] src_exp;
      logic [MAN_W-1:0] mant_d;
      logic [MAN_W-1:0] mant_q;
      logic [EXP_W-1:0] exp_q;
      logic             vld_q;
      logic             ovf_q;
`ifdef FP_SHIFTER_STICKY_EN
      logic             src_loss;
      logic             loss_d;
      logic             loss_q;
`endif

      if (s == 0) begin : g_head
         assign src_vld  = in_valid;
         assign src_left = pre_left;
         assign src_ovf  = pre_ovf;
         assign src_amt  = pre_amt;
         assign src_mant = pre_mant;
         assign src_exp  = pre_exp;
`ifdef FP_SHIFTER_STICKY_EN
         assign src_loss = pre_loss;
`endif
      end else begin : g_link
         assign src_vld  = g_stage[s-1].vld_q;
         assign src_left = g_stage[s-1].g_fwd.left_q;
         assign src_ovf  = g_stage[s-1].ovf_q;
         assign src_amt  = g_stage[s-1].g_fwd.amt_q;
         assign src_mant = g_stage[s-1].mant_q;
         assign src_exp  = g_stage[s-1].exp_q;
`ifdef FP_SHIFTER_STICKY_EN
         assign src_loss = g_stage[s-1].loss_q;
`endif
      end

      // Shift bit b belongs to stage b*STAGES/SH_W: disjoint, and every bit lands in some stage.
      always_comb begin : p_shift
         mant_d = src_mant;
`ifdef FP_SHIFTER_STICKY_EN
         loss_d = src_loss;
`endif
         for (int unsigned b = 0; b < SH_W; b++) begin
            if ((((b * STAGES) / SH_W) == SIDX) && src_amt[b]) begin
               if (src_left) begin
`ifdef FP_SHIFTER_STICKY_EN
                  loss_d = loss_d | (|(mant_d >> (MAN_W - (1 << b))));
`endif
                  mant_d = mant_d << (1 << b);
               end else begin
`ifdef FP_SHIFTER_STICKY_EN
                  loss_d = loss_d | (|(mant_d << (MAN_W - (1 << b))));
`endif
                  mant_d = mant_d >> (1 << b);
               end
            end
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic            left_q;
         logic [SH_W-1:0] amt_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               left_q <= 1'b0;
               amt_q  <= '0;
            end else if (en) begin
               left_q <= src_left;
               amt_q  <= src_amt;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= 1'b0;
            mant_q <= '0;
            exp_q  <= '0;
            ovf_q  <= 1'b0;
`ifdef FP_SHIFTER_STICKY_EN
            loss_q <= 1'b0;
`endif
         end else if (en) begin
            vld_q  <= src_vld;
            mant_q <= mant_d;
            exp_q  <= src_exp;
            ovf_q  <= src_ovf;
`ifdef FP_SHIFTER_STICKY_EN
            loss_q <= loss_d;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)     zero_q <= 1'b0;
      else if (en) zero_q <= ~|g_stage[STAGES-1].mant_d;
   end

   assign out_valid  = g_stage[STAGES-1].vld_q;
   assign exp_out    = g_stage[STAGES-1].exp_q;
   assign mantis_out = g_stage[STAGES-1].mant_q;
   assign ovf        = g_stage[STAGES-1].ovf_q;
   assign zero       = zero_q;
`ifdef FP_SHIFTER_STICKY_EN
   assign loss       = g_stage[STAGES-1].loss_q;
`else
   assign loss       = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: behavioural model results queued on accept, compared on output.
module tb_fp_align_shifter;

   localparam int unsigned EW = 8;
   localparam int unsigned MW = 28;
   localparam int unsigned ST = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    t_op = '0;
   logic [EW-1:0] t_exp = '0;
   logic [MW-1:0] t_man = '0;
   logic [EW-1:0] t_arg = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [EW-1:0] exp_out;
   logic [MW-1:0] mantis_out;
   logic          loss, ovf, zero;

   typedef struct packed {
      logic [EW-1:0] e;
      logic [MW-1:0] m;
      logic          l;
      logic          o;
      logic          z;
   } res_t;

   typedef struct {
      logic [1:0]    o;
      logic [EW-1:0] e;
      logic [MW-1:0] m;
      logic [EW-1:0] a;
   } vec_t;

   res_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned rdy_mode = 0;
   int unsigned pidx = 0;
   logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   vec_t        vecs [14];

   fp_align_shifter #(.EXP_W(EW), .MAN_W(MW), .STAGES(ST)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(t_op), .exp(t_exp), .mantis(t_man), .exp_arg(t_arg),
      .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
      .mantis_out(mantis_out), .loss(loss), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic void rshift(input logic [MW-1:0] m, input logic [EW-1:0] a,
                                  output logic [MW-1:0] q, output logic l);
      logic [2*MW-1:0] w;
      if (a >= MW) begin
         q = '0;
         l = |m;
      end else begin
         w = {m, {MW{1'b0}}} >> a;
         q = w[2*MW-1:MW];
         l = |w[MW-1:0];
      end
   endfunction

   function automatic res_t model(input logic [1:0] o, input logic [EW-1:0] e,
                                  input logic [MW-1:0] m, input logic [EW-1:0] a);
      res_t            r;
      logic [2*MW-1:0] w;
      logic [EW:0]     s;
      logic [MW-1:0]   q;
      logic            l;
      int unsigned     lz, sh;
      r.e = e; r.m = m; r.l = 1'b0; r.o = 1'b0;
      case (o)
         2'd0: begin
            r.e = e - a;
            if (a >= MW) begin
               r.m = '0;
               r.l = |m;
            end else begin
               w   = {{MW{1'b0}}, m} << a;
               r.m = w[MW-1:0];
               r.l = |w[2*MW-1:MW];
            end
         end
         2'd1: begin
            s   = {1'b0, e} + {1'b0, a};
            r.o = s[EW];
            r.e = s[EW-1:0];
            if (s[EW] || (r.e == {EW{1'b1}})) begin
               r.e = '1;
               r.m = '0;
               r.l = |m;
            end else begin
               rshift(m, a, q, l);
               r.m = q; r.l = l;
            end
         end
         2'd2: begin
            if (a < e) begin
               r.o = 1'b1;
            end else begin
               r.e = a;
               rshift(m, a - e, q, l);
               r.m = q; r.l = l;
            end
         end
         default: begin
            if (m == '0) begin
               r.e = '0;
               r.m = '0;
            end else begin
               lz = 0;
               while (!m[MW-1-lz]) lz++;
               sh  = (lz < e) ? lz : 32'(e);
               r.e = e - EW'(sh);
               r.m = m << sh;
            end
         end
      endcase
      r.z = (r.m == '0);
`ifndef FP_SHIFTER_STICKY_EN
      r.l = 1'b0;
`endif
      return r;
   endfunction

   // Output checks run every valid cycle against the queue head, so a stalled beat is re-checked.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check_val("spurious_valid", out_valid, 0);
            end else begin
               check_val("exp_out", exp_out, sb[0].e);
               check_val("mantis_out", mantis_out, sb[0].m);
               check_val("loss", loss, sb[0].l);
               check_val("ovf", ovf, sb[0].o);
               check_val("zero", zero, sb[0].z);
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (in_valid && in_ready) sb.push_back(model(t_op, t_exp, t_man, t_arg));
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               out_ready = pat[pidx];
               pidx      = (pidx + 1) % 4;
            end
            default: out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic send(input logic [1:0] o, input logic [EW-1:0] e,
                       input logic [MW-1:0] m, input logic [EW-1:0] a);
      int unsigned w = 0;
      t_op = o; t_exp = e; t_man = m; t_arg = a;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check_val("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int unsigned w = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check_val("drain", sb.size(), 0);
   endtask

   initial begin
      int unsigned n;
      vecs[0]  = '{2'd1, 8'h10, 28'h8000001, 8'h04};
      vecs[1]  = '{2'd1, 8'hFE, 28'h1234567, 8'h05};
      vecs[2]  = '{2'd3, 8'h03, 28'h0000F00, 8'h00};
      vecs[3]  = '{2'd3, 8'h55, 28'h0000000, 8'h11};
      vecs[4]  = '{2'd2, 8'h20, 28'h1234567, 8'h10};
      vecs[5]  = '{2'd2, 8'h20, 28'h1234567, 8'h40};
      vecs[6]  = '{2'd0, 8'h40, 28'h0ABCDEF, 8'h08};
      vecs[7]  = '{2'd0, 8'h05, 28'h0000001, 8'h1B};
      vecs[8]  = '{2'd0, 8'h05, 28'hFFFFFFF, 8'h1C};
      vecs[9]  = '{2'd1, 8'h10, 28'hFFFFFFF, 8'h1B};
      vecs[10] = '{2'd1, 8'h10, 28'hFFFFFFF, 8'h1C};
      vecs[11] = '{2'd1, 8'h7F, 28'h0000003, 8'h80};
      vecs[12] = '{2'd3, 8'h40, 28'h0000001, 8'h00};
      vecs[13] = '{2'd2, 8'h10, 28'h0000005, 8'h10};

      rdy_mode = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_exp_out", exp_out, 0);
      check_val("rst_mantis_out", mantis_out, 0);
      check_val("rst_loss", loss, 0);
      check_val("rst_ovf", ovf, 0);
      check_val("rst_zero", zero, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("in_ready_after_rst", in_ready, 1);

      // Exact latency through an empty pipeline
      @(posedge clk);
      #1;
      send(2'd1, 8'h10, 28'h8000001, 8'h04);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("latency", n, ST);
      drain();

      foreach (vecs[i]) send(vecs[i].o, vecs[i].e, vecs[i].m, vecs[i].a);
      drain();

      rdy_mode = 1;
      for (int i = 0; i < 200; i++) begin
         send(2'($urandom_range(0, 3)), EW'($urandom), MW'($urandom),
              ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 40)) : EW'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      drain();

      rdy_mode = 2;
      pidx = 0;
      for (int i = 0; i < 12; i++)
         send(2'(i % 4), EW'(8'h30 + i), MW'(28'h0F0F0F1 << i), EW'(i + 2));
      drain();

      // Reset with two beats in flight and the output stalled
      rdy_mode = 3;
      repeat (2) @(posedge clk);
      #1;
      send(2'd1, 8'h10, 28'h8000001, 8'h04);
      send(2'd0, 8'h20, 28'h0000F00, 8'h02);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_flush_valid", out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      check_val("rst_mid_in_ready", in_ready, 1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      send(2'd3, 8'h03, 28'h0000F00, 8'h00);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
